// File: rtl/serial_subtractor8bits_pkg.sv
// Shared types and bit-level helpers for the bit-serial subtractor.
package serial_subtractor8bits_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Default operand width.
    localparam int unsigned DefaultWidth = 8;

    // Difference bit of a - b - borrow_in.
    function automatic logic fs_diff(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Borrow-out of a - b - borrow_in.
    function automatic logic fs_borrow(input logic a, input logic b, input logic c);
        return (~a & b) | (~(a ^ b) & c);
    endfunction

endpackage

// File: rtl/serial_subtractor8bits_full_subtractor.sv
// 1-bit full subtractor: res_o = a_i - b_i - c_i, c_o = borrow-out.
module full_subtractor
    import serial_subtractor8bits_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic res_o,
    output logic c_o
);

    assign res_o = fs_diff(a_i, b_i, c_i);
    assign c_o   = fs_borrow(a_i, b_i, c_i);

endmodule

// File: rtl/serial_subtractor8bits.sv
// Bit-serial WIDTH-bit subtractor: res = a - b - c_i, one bit per clock, LSB first.
module serial_subtractor8bits
    import serial_subtractor8bits_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic             c_o,
    output logic             ovf_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Holds the WIDTH-1 low result bits; the final bit comes straight from the subtractor.
    logic [WIDTH-2:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               borrow_q, borrow_d;
    logic               c_q, c_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               bit_diff;
    logic               bit_borrow;
    logic               last_bit;
    logic [WIDTH-1:0]   sr_ext;

    full_subtractor u_full_subtractor (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .c_i   (borrow_q),
        .res_o (bit_diff),
        .c_o   (bit_borrow)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign sr_ext   = {bit_diff, sr_q};

    // Next-state logic for the controller and serial datapath.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sr_d     = sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        c_d      = c_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    borrow_d = c_i;
                    cnt_d    = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                borrow_d = bit_borrow;
                sr_d     = sr_ext[WIDTH-1:1];
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // a_q[0]/b_q[0] now hold the captured operand MSBs.
                    res_d   = sr_ext;
                    c_d     = bit_borrow;
                    ovf_d   = (a_q[0] != b_q[0]) && (bit_diff != a_q[0]);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sr_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            c_q      <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sr_q     <= sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            c_q      <= c_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone);
    assign res_o  = res_q;
    assign c_o    = c_q;
    assign ovf_o  = ovf_q;

endmodule
